// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS32 main control unit:
// FSM state encoding, opcode/funct values, ALU op classes, PC mux selects.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALUC_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALUC_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b111;

  // 2'b10 is not a legal PC mux select and is never driven.
  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control <-> datapath bundle.
//   master: the control unit (takes op/funct/zero, drives all selects/enables)
//   slave : the datapath side (drives op/funct/zero, takes the controls)
interface mips_multicycle_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic               pcen;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [ALUC_W-1:0]  alucontrol;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state_o
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state_o
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_dec.sv
// ALU decoder: maps the FSM's ALU op class plus instruction funct field to
// the 3-bit ALU control. Purely combinational.
//   aluop_i      : ADD / SUB / FUNCT
//   funct_i      : instr[5:0]
//   alucontrol_o : ALU operation select
module alu_dec
  import mips_ctrl_pkg::*;
(
  input  aluop_t              aluop_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  output logic [ALUC_W-1:0]   alucontrol_o
);

  always_comb begin
    alucontrol_o = ALUC_ADD;
    case (aluop_i)
      ALU_SUB:   alucontrol_o = ALUC_SUB;
      ALU_FUNCT: begin
        // Unknown funct codes quietly fall back to add.
        case (funct_i)
          FN_SUB:  alucontrol_o = ALUC_SUB;
          FN_AND:  alucontrol_o = ALUC_AND;
          FN_OR:   alucontrol_o = ALUC_OR;
          FN_SLT:  alucontrol_o = ALUC_SLT;
          default: alucontrol_o = ALUC_ADD;
        endcase
      end
      default:   alucontrol_o = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 main control unit. Moore FSM sequencing one instruction
// over 2-5 cycles; all controls are decoded combinationally from the state
// (plus op/funct/zero where needed). The state register is the only flop.
//   clk     : core clock, rising edge
//   reset_n : asynchronous active-low reset, clears the FSM to FETCH
//   bus     : master side of mips_multicycle_ctrl_if (op/funct/zero in,
//             mux selects, write enables, alucontrol, illegal_op, state_o out)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  mips_multicycle_ctrl_if.master  bus
);

  state_t      state_q, state_d;
  aluop_t      aluop;
  logic        pcwrite, branch;
  logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic        illegal;
  logic [1:0]  alusrcb, pcsrc;
  logic [ALUC_W-1:0] alucontrol;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // Next state and per-state controls; selects default to their FETCH values.
  always_comb begin
    state_d  = state_q;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_FOUR;
    aluop    = ALU_ADD;
    pcsrc    = PCSRC_ALURES;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    illegal  = 1'b0;

    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH2;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = FETCH;
      end
      EXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_B;
        aluop   = ALU_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        alusrca = 1'b1;
        alusrcb = SRCB_B;
        aluop   = ALU_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  alu_dec u_alu_dec (
    .aluop_i      (aluop),
    .funct_i      (bus.funct),
    .alucontrol_o (alucontrol)
  );

  // Enables are gated by reset_n so nothing writes while reset is held.
  assign bus.pcen       = reset_n & (pcwrite | (branch & bus.zero));
  assign bus.irwrite    = reset_n & irwrite;
  assign bus.regwrite   = reset_n & regwrite;
  assign bus.memwrite   = reset_n & memwrite;
  assign bus.illegal_op = reset_n & illegal;
  assign bus.iord       = iord;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed instructions from the
// test plan followed by a random instruction stream, checked per cycle against
// an instruction-level model (class + cycle index -> expected controls).
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_J, C_ILL} cls_t;

  typedef struct packed {
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
    logic       illegal;
  } ctl_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic cls_t classify(input logic [5:0] op);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  // Instruction-level trace: which state numbers the instruction visits.
  function automatic void trace(input cls_t c, output int len, output int st[5]);
    st = '{0, 1, 0, 0, 0};
    case (c)
      C_LW:   begin len = 5; st[2] = 2; st[3] = 3; st[4] = 4; end
      C_SW:   begin len = 4; st[2] = 2; st[3] = 5; end
      C_R:    begin len = 4; st[2] = 6; st[3] = 7; end
      C_BEQ:  begin len = 3; st[2] = 8; end
      C_ADDI: begin len = 4; st[2] = 9; st[3] = 10; end
      C_J:    begin len = 3; st[2] = 11; end
      default: len = 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected controls for cycle k of an instruction of class c.
  function automatic ctl_t expect_ctl(input cls_t c, input int k, input logic [5:0] f, input logic z);
    ctl_t e;
    e = '0;
    e.alusrcb = 2'b01;
    e.aluc    = 3'b010;
    if (k == 0) begin
      e.pcen = 1'b1; e.irwrite = 1'b1;
    end else if (k == 1) begin
      e.alusrcb = 2'b11; e.illegal = (c == C_ILL);
    end else begin
      case (c)
        C_LW, C_SW: begin
          if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
          else if (c == C_SW) begin e.iord = 1'b1; e.memwrite = 1'b1; end
          else if (k == 3) e.iord = 1'b1;
          else begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
        end
        C_R: begin
          if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b00; e.aluc = funct_alu(f); end
          else begin e.regdst = 1'b1; e.regwrite = 1'b1; end
        end
        C_BEQ: begin
          e.alusrca = 1'b1; e.alusrcb = 2'b00; e.aluc = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
        end
        C_ADDI: begin
          if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
          else e.regwrite = 1'b1;
        end
        C_J: begin e.pcsrc = 2'b11; e.pcen = 1'b1; end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o.pcen = bus.pcen;         o.iord = bus.iord;         o.memwrite = bus.memwrite;
    o.irwrite = bus.irwrite;   o.regdst = bus.regdst;     o.memtoreg = bus.memtoreg;
    o.regwrite = bus.regwrite; o.alusrca = bus.alusrca;   o.alusrcb = bus.alusrcb;
    o.pcsrc = bus.pcsrc;       o.aluc = bus.alucontrol;   o.illegal = bus.illegal_op;
    return o;
  endfunction

  // Entered and left at a falling edge where the DUT is expected in FETCH.
  // zmode: 0/1 force zero, 2 random. abort_at >= 0 drops reset in that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode,
                           input int abort_at);
    cls_t c;
    int   len;
    int   st[5];
    logic z;
    c = classify(op);
    trace(c, len, st);
    bus.op    = op;
    bus.funct = f;
    for (int k = 0; k < len; k++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.zero = z;
      #1;
      chk("state", 32'(bus.state_o), 32'(st[k]));
      chk("ctl", 32'(observe()), 32'(expect_ctl(c, k, f, z)));
      chk("pcsrc_legal", 32'(bus.pcsrc == 2'b10), 32'd0);
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("abort_regwrite", 32'(bus.regwrite), 32'd0);
        chk("abort_state", 32'(bus.state_o), 32'd0);
        chk("abort_pcen", 32'(bus.pcen), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  logic [5:0] ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
  logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

  initial begin
    bus.op = '0; bus.funct = '0; bus.zero = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_enables", 32'({bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite, bus.illegal_op}), 32'd0);
    chk("rst_aluc", 32'(bus.alucontrol), 32'b010);
    chk("rst_srcb", 32'(bus.alusrcb), 32'b01);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed: LW, SW, R-type slt, BEQ taken/not taken, J, illegal.
    run_instr(6'b100011, 6'b000000, 2, -1);
    run_instr(6'b101011, 6'b000000, 2, -1);
    run_instr(6'b000000, 6'b101010, 1, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    run_instr(6'b000010, 6'b000000, 1, -1);
    run_instr(6'b111111, 6'b000000, 1, -1);
    run_instr(6'b001000, 6'b000000, 1, -1);
    // Abort LW in MEMWB.
    run_instr(6'b100011, 6'b000000, 2, 4);
    run_instr(6'b000000, 6'b100101, 2, -1);

    // Random instruction stream, occasional aborts.
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op, f;
      int ab;
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      f  = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 1)) : -1;
      run_instr(op, f, 2, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
